mem_stage: RTL

Memory-access stage sitting directly downstream of the ALU. It accepts one request per transaction: ALU result, RAM word address derived from that result, store data and load/store controls. It performs the load or store on an internal single-port data RAM, then presents one write-back word: load data, or the ALU result passed through. Multi-cycle FSM with a valid/ready request handshake and a one-cycle write-back strobe.

---
 rtl/mem_stage_pkg.sv | 36 +++
 rtl/data_ram.sv | 32 +++
 rtl/mem_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and default widths for the memory-access stage.
//   - MEM_DATA_W / MEM_ADDR_W : default data and word-address widths
//   - state_e                 : FSM states (idle, read, write, response)
//   - req_kind_e              : decoded request kind
//   - decode_req()            : maps the mem_read/mem_write pair to a request kind
package mem_stage_pkg;

    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_ADDR_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        ReqLoad,
        ReqStore,
        ReqPass,
        ReqIllegal
    } req_kind_e;

    function automatic req_kind_e decode_req(input logic rd, input logic wr);
        req_kind_e kind;
        case ({rd, wr})
            2'b10:   kind = ReqLoad;
            2'b01:   kind = ReqStore;
            2'b00:   kind = ReqPass;
            default: kind = ReqIllegal;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/data_ram.sv
// data_ram: single-port synchronous RAM, DEPTH x DATA_W, no reset.
//   i_clk   : clock
//   i_we    : write enable, write takes effect on the rising edge
//   i_addr  : word address shared by read and write
//   i_wdata : write data
//   o_rdata : registered read data, valid one cycle after i_addr is presented
module data_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read returns the pre-write contents when reading and writing the same word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage following the ALU. Accepts one request at a time,
// performs a load or store on the internal data RAM, and emits one write-back word.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_req_valid         : request present
//   o_req_ready         : stage idle and able to accept
//   i_mem_read          : request is a load
//   i_mem_write         : request is a store (both set = illegal)
//   i_ram_address       : RAM word address
//   i_alu_result        : ALU result, passed through for non-loads
//   i_store_data        : store data
//   o_wb_valid          : one-cycle write-back strobe
//   o_wb_data           : write-back word, held until the next strobe
//   o_wb_we             : destination register write enable, qualified by o_wb_valid
//   o_busy              : transaction in flight
//   o_err               : one-cycle pulse with o_wb_valid for an illegal request
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_ram_address,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_store_data,
    output logic              o_wb_valid,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_wb_we,
    output logic              o_busy,
    output logic              o_err
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_store_data;
    logic              r_wb_valid;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_wb_we;
    logic              r_err;

    req_kind_e         w_kind;
    logic              w_accept;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_rdata;

    assign o_req_ready = (r_state == StIdle);
    assign o_busy      = (r_state != StIdle);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_kind      = decode_req(i_mem_read, i_mem_write);

    // The RAM sees the live address while idle so a load's read is launched on the
    // accept edge; its data is then ready during RD and lands in wb_data entering RESP.
    // The write strobe decodes the state, so an async reset in WR cancels the write.
    assign w_ram_we   = (r_state == StWr);
    assign w_ram_addr = (r_state == StIdle) ? i_ram_address : r_addr;

    data_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_data_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_store_data),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_addr       <= '0;
            r_alu_result <= '0;
            r_store_data <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_data    <= '0;
            r_wb_we      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_addr       <= i_ram_address;
                        r_alu_result <= i_alu_result;
                        r_store_data <= i_store_data;
                        case (w_kind)
                            ReqLoad:  r_state <= StRd;
                            ReqStore: r_state <= StWr;
                            ReqPass: begin
                                r_state    <= StResp;
                                r_wb_valid <= 1'b1;
                                r_wb_data  <= i_alu_result;
                                r_wb_we    <= 1'b1;
                            end
                            default: begin
                                // Illegal: behaves as a pass with no register write.
                                r_state    <= StResp;
                                r_wb_valid <= 1'b1;
                                r_wb_data  <= i_alu_result;
                                r_wb_we    <= 1'b0;
                                r_err      <= 1'b1;
                            end
                        endcase
                    end
                end
                StRd: begin
                    r_state    <= StResp;
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= w_ram_rdata;
                    r_wb_we    <= 1'b1;
                end
                StWr: begin
                    r_state    <= StResp;
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= r_alu_result;
                    r_wb_we    <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_wb_valid = r_wb_valid;
    assign o_wb_data  = r_wb_data;
    assign o_wb_we    = r_wb_we;
    assign o_err      = r_err;

endmodule
